// File: rtl/token_router_pkg.sv
// Shared constants and types for the token-arbitrated buffer controller.
// Optional packet locking is enabled with PACKET_LOCK_EN.
package token_router_pkg;

  localparam int FLIT_W        = 55;
  localparam int TAIL_BIT      = FLIT_W - 1;
  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_NUM_SLOTS = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int TOK_W = idx_w(DEF_NUM_REQ);
  localparam int PTR_W = idx_w(DEF_NUM_SLOTS);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_e;

endpackage

// File: rtl/token_buffer_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first masked requester at or after token.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int TW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [TW-1:0] token_i,
  input  logic [N-1:0]  mask_i,
  output logic [N-1:0]  grant_o,
  output logic [TW-1:0] idx_o,
  output logic          any_o
);
  logic [N-1:0] req_m;

  assign req_m = req_i & mask_i;
  assign any_o = |req_m;

  always_comb begin
    logic          found;
    logic [TW-1:0] j;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = '0;
    for (int k = 0; k < N; k++) begin
      j = TW'((int'(token_i) + k) % N);
      if (!found && req_m[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = j;
      end
    end
  end

endmodule

// File: rtl/token_buffer_ctrl.sv
// Shares a bank of flit buffers among router inputs as a circular FIFO.
// Define PACKET_LOCK_EN to keep multi-flit packets contiguous (tail = flit MSB).
module token_buffer_ctrl
  import token_router_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int WIDTH     = FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_SLOTS-1:0]       buf_sel,
  output logic [WIDTH-1:0]           buf_wdata,
  input  logic [NUM_SLOTS*WIDTH-1:0] buf_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       full,
  output logic                       empty
);
  localparam int TW = idx_w(NUM_REQ);
  localparam int PW = idx_w(NUM_SLOTS);
  localparam int CW = PW + 1;

  logic [NUM_REQ-1:0][WIDTH-1:0]   req_v;
  logic [NUM_SLOTS-1:0][WIDTH-1:0] rd_v;

  logic [TW-1:0] token_q, token_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic [NUM_REQ-1:0] arb_mask, arb_grant;
  logic [TW-1:0]      win_idx, win_inc;
  logic               arb_any, push, pop, tok_upd;

  assign req_v = req_data;
  assign rd_v  = buf_rdata;

  rr_arbiter #(.N(NUM_REQ), .TW(TW)) u_arb (
    .req_i   (req),
    .token_i (token_q),
    .mask_i  (arb_mask),
    .grant_o (arb_grant),
    .idx_o   (win_idx),
    .any_o   (arb_any)
  );

  assign full    = (count_q == CW'(NUM_SLOTS));
  assign empty   = (count_q == '0);
  // Held off during reset so the buffers never see a write while cleared.
  assign push    = arb_any & ~full & rst;
  assign pop     = out_valid & out_ready;
  assign win_inc = (win_idx == TW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef PACKET_LOCK_EN
  lock_state_e   state_q, state_d;
  logic [TW-1:0] owner_q, owner_d;
  logic          tail;

  assign tail = req_v[win_idx][WIDTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNLOCKED;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      UNLOCKED: if (push && !tail) begin
        state_d = LOCKED;
        owner_d = win_idx;
      end
      LOCKED:   if (push && tail) state_d = UNLOCKED;
      default:  state_d = UNLOCKED;
    endcase
  end

  // While locked only the owner competes; its tail flit advances the token.
  always_comb begin
    arb_mask = '1;
    tok_upd  = push;
    if (state_q == LOCKED) begin
      arb_mask          = '0;
      arb_mask[owner_q] = 1'b1;
      tok_upd           = push & tail;
    end
  end
`else
  assign arb_mask = '1;
  assign tok_upd  = push;
`endif

  assign grant = push ? arb_grant : '0;

  always_comb begin
    buf_sel   = '0;
    buf_wdata = '0;
    if (push) begin
      buf_sel[wr_ptr_q] = 1'b1;
      buf_wdata         = req_v[win_idx];
    end
  end

  assign out_valid = ~empty;
  assign out_data  = rd_v[rd_ptr_q];

  assign token_d  = tok_upd ? win_inc : token_q;
  assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      token_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      token_q  <= token_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: doc/token_buffer_ctrl.md
Name: token_buffer_ctrl

Overview:
- Controller that shares a bank of NUM_SLOTS 55-bit buffer registers among NUM_REQ router input ports, using a rotating token for round-robin arbitration.
- Drives each buffer's buffer_select and the shared new_value bus. Sequences the slots as a circular FIFO. Presents the oldest flit to the downstream output stage over a valid/ready handshake.

Parameters:
- NUM_REQ, 4, number of requesting input ports (≥2).
- NUM_SLOTS, 4, number of buffer instances managed (power of two, ≥2).
- WIDTH, 55, flit width; matches the buffer register width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- req  input  NUM_REQ  per-port write request, level; held until granted
- req_data  input  NUM_REQ*WIDTH  per-port flit; port i occupies bits [i*WIDTH +: WIDTH]
- grant  output  NUM_REQ  one-hot; high in the cycle port i's flit is written
- buf_sel  output  NUM_SLOTS  one-hot buffer_select to each buffer instance
- buf_wdata  output  WIDTH  shared new_value bus to all buffers
- buf_rdata  input  NUM_SLOTS*WIDTH  concatenated buffer outputs
- out_valid  output  1  a flit is available
- out_ready  input  1  downstream accepts the flit
- out_data  output  WIDTH  oldest buffered flit
- full  output  1  count == NUM_SLOTS
- empty  output  1  count == 0

Behaviour:
- State registers: token (log2 NUM_REQ), wr_ptr and rd_ptr (log2 NUM_SLOTS), count (log2 NUM_SLOTS + 1).
- Reset values: all registers 0. grant = 0, buf_sel = 0, out_valid = 0, empty = 1, full = 0.
- Arbitration is combinational from the registered token and req:
  - winner = first i with req[i] = 1, searching token, token+1, … modulo NUM_REQ.
  - push = any req and !full.
  - grant = onehot(winner) when push, else 0.
- Write path:
  - When push: buf_sel = onehot(wr_ptr), buf_wdata = req_data[winner]. The buffer captures on the same clk edge.
  - When not push: buf_sel = 0, buf_wdata = 0.
  - On push: wr_ptr++ (wraps NUM_SLOTS-1 -> 0); token <= winner+1 mod NUM_REQ.
  - On no push: token holds.
- Read path:
  - out_valid = (count != 0); out_data = buf_rdata slot rd_ptr.
  - pop = out_valid & out_ready; on pop rd_ptr++ with wrap.
  - Stale slot contents are not cleared.
- Count update:
  - push & !pop: +1. pop & !push: −1. Both or neither: unchanged.
  - Push while full is blocked: grant = 0, requests wait. A pop in that same cycle does not enable a push; the push happens the next cycle.
  - Push into an empty bank is visible on out_data the next cycle; there is no bypass. Write-to-read latency is 1 cycle.
- out_valid may rise without out_ready. Once asserted, out_data stays stable until pop.
- Asynchronous reset mid-operation clears all state immediately. Buffered flits are discarded (the buffers share rst).
- grant and buf_sel are never asserted together with full = 1.

Optional Feature:
- Macro: PACKET_LOCK_EN.
- With the macro defined, the controller adds a 2-state FSM:
  - UNLOCKED: normal arbitration. A push whose flit has bit WIDTH-1 (tail) = 0 records the winner as owner and moves to LOCKED.
  - LOCKED: only req[owner] is considered and the token is frozen. A push of a flit with tail = 1 returns to UNLOCKED and sets token <= owner+1. A single-flit packet (tail = 1) never enters LOCKED.
  - Full stalls in LOCKED without leaving the state.
  - Reset enters UNLOCKED.
- Without the macro: flit-level round-robin only, no FSM, bit WIDTH-1 is ignored.

Decomposition:
- Shared package token_router_pkg:
  - FLIT_W = 55, TAIL_BIT = 54.
  - Lock state typedef {UNLOCKED, LOCKED}.
  - clog2-based pointer-width constants.
- One sub-module: rr_arbiter. Inputs: req, token, optional mask. Output: one-hot grant and index. Purely combinational.

Test Plan:
- Reset, then req = 4'b0000 for 5 cycles -> grant = 0, buf_sel = 0, empty = 1, out_valid = 0 throughout.
- req = 4'b1111, out_ready = 0, token = 0 -> grants 0001, 0010, 0100, 1000 on successive cycles. buf_sel walks 0001 -> 1000. full = 1 on cycle 5, grant = 0 on cycle 5.
- Full bank, out_ready = 1 and req[2] = 1 held -> cycle 1: pop only (count 4 -> 3). Cycle 2: push and pop together, count stays 3. buf_sel = 0001, confirming wr_ptr wraps to 0.
- Single push of 55'h7_1234_5678_9ABC from port 3 into an empty bank -> out_valid = 1 and out_data = 55'h7_1234_5678_9ABC on the next cycle. Token becomes 0.
- Assert rst low mid-burst with count = 2 -> count = 0, out_valid = 0, token = 0 immediately. The first post-reset request wins from port 0.
- PACKET_LOCK_EN: port 1 sends flits with tail = 0, 0, 1 while port 0 requests continuously -> grants 0010 ×3, then 0001. Token then = 1.
